spmv_hbm_rd_stream: RTL

HBM read-stream engine feeding the SpMV kernels. It converts a (base address, beat count) command into a sequence of AXI4 INCR read bursts on one HBM pseudo-channel and delivers the returned 256-bit beats as an in-order AXI-Stream with `tlast` on the final beat. One instance sits directly upstream of each kernel ColXi port and of the Val port inside `spmv_calc_top`.

---
 rtl/spmv_hbm_rd_stream_pkg.sv | 29 ++
 rtl/spmv_hbm_rd_stream_fifo.sv | 80 ++++++++
 rtl/spmv_hbm_rd_stream.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/spmv_hbm_rd_stream_pkg.sv
// Shared AXI encodings, HBM geometry and the read-stream FSM state type
// used by the SpMV HBM read-stream engine.
package spmv_pkg;

  localparam int unsigned HBM_ADDR_W = 48;
  localparam int unsigned HBM_DATA_W = 256;
  localparam int unsigned BEAT_BYTES = 32;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int unsigned PAGE_BYTES = 4096;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

  // Beats remaining before the next 4 KB page boundary (1..128 for aligned beats).
  function automatic logic [31:0] beats_to_page_end(input logic [11:0] page_off);
    logic [12:0] bytes_left;
    bytes_left = 13'(PAGE_BYTES) - {1'b0, page_off};
    return 32'(bytes_left >> BEAT_SHIFT);
  endfunction

endpackage

// File: rtl/spmv_hbm_rd_stream_fifo.sv
// Synchronous return-data FIFO with a registered output stage; free_cnt
// counts against DEPTH including the beat held in the output register.
module spmv_stream_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    mem_cnt;
  logic             wr_en;
  logic             rd_en;
  logic             load;
  logic             bypass;
  logic             mem_wr;
  logic             mem_rd;

  // The output register is a spare slot beyond the DEPTH budgeted in free_cnt,
  // so a fully credited window never pulls in_ready low.
  assign in_ready = (mem_cnt != CW'(DEPTH));
  assign free_cnt = CW'(DEPTH) - mem_cnt - CW'(out_valid);

  always_comb begin
    wr_en  = in_valid && in_ready;
    rd_en  = out_valid && out_ready;
    load   = ((mem_cnt != '0) || wr_en) && (!out_valid || rd_en);
    bypass = load && (mem_cnt == '0);
    mem_wr = wr_en && !bypass;
    mem_rd = load && (mem_cnt != '0);
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (mem_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({mem_wr, mem_rd})
        2'b10:   mem_cnt <= mem_cnt + CW'(1);
        2'b01:   mem_cnt <= mem_cnt - CW'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= bypass ? in_data : mem[rd_ptr];
      end else if (rd_en) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spmv_hbm_rd_stream.sv
// HBM read-stream engine: splits a (base, beats) command into 4 KB-safe AXI4
// INCR bursts under a FIFO credit window and streams the beats out in order.
module spmv_hbm_rd_stream
  import spmv_pkg::*;
#(
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned FIFO_DEPTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [HBM_ADDR_W-1:0] cmd_addr,
  input  logic [31:0]           cmd_beats,
  output logic [HBM_ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [HBM_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [HBM_DATA_W-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  rd_state_e             state;
  rd_state_e             state_nxt;
  logic                  init_q;
  logic [HBM_ADDR_W-1:0] addr_q;
  logic [31:0]           remain_q;
  logic [31:0]           total_q;
  logic [31:0]           out_cnt_q;
  logic [CW-1:0]         reserved_q;
  logic [OW-1:0]         inflight_q;
  logic                  err_q;

  logic [CW-1:0]         free_cnt;
  logic                  fifo_in_ready;
  logic [31:0]           page_beats;
  logic [31:0]           burst_len;
  logic                  credit_ok;
  logic                  ar_go;
  logic                  cmd_hs;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  rlast_hs;
  logic                  t_hs;

  always_comb begin
    page_beats = beats_to_page_end(addr_q[11:0]);
    burst_len  = remain_q;
    if (burst_len > MAX_BURST) begin
      burst_len = MAX_BURST;
    end
    if (burst_len > page_beats) begin
      burst_len = page_beats;
    end
  end

  // Space is only granted against free entries not already promised to bursts in flight.
  assign credit_ok = (32'(free_cnt) >= 32'(reserved_q) + burst_len) &&
                     (32'(inflight_q) < MAX_OUTSTANDING);

  assign cmd_hs   = cmd_valid && cmd_ready;
  assign ar_hs    = ar_go && m_axi_arready;
  assign r_hs     = m_axi_rvalid && m_axi_rready;
  assign rlast_hs = r_hs && m_axi_rlast;
  assign t_hs     = m_axis_tvalid && m_axis_tready;

  assign m_axi_rready  = init_q && fifo_in_ready;
  assign m_axis_tlast  = m_axis_tvalid && (out_cnt_q == total_q - 32'd1);
  assign err           = err_q;

  // AR fields are combinational from registered state, so they hold until arready.
  assign m_axi_arvalid = ar_go;
  assign m_axi_araddr  = ar_go ? addr_q : '0;
  assign m_axi_arlen   = ar_go ? 8'(burst_len - 32'd1) : '0;
  assign m_axi_arsize  = ar_go ? AXI_SIZE_32B : '0;
  assign m_axi_arburst = ar_go ? AXI_BURST_INCR : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    ar_go     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = init_q;
        if (cmd_valid && init_q) begin
          state_nxt = (cmd_beats == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ar_go = credit_ok;
        if (ar_go && m_axi_arready && (burst_len == remain_q)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (t_hs && m_axis_tlast) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_q    <= 1'b0;
      addr_q    <= '0;
      remain_q  <= '0;
      total_q   <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (cmd_hs) begin
        addr_q    <= cmd_addr & ~HBM_ADDR_W'(BEAT_BYTES - 1);
        remain_q  <= cmd_beats;
        total_q   <= cmd_beats;
        out_cnt_q <= '0;
        err_q     <= 1'b0;
      end else begin
        if (ar_hs) begin
          addr_q   <= addr_q + (HBM_ADDR_W'(burst_len) << BEAT_SHIFT);
          remain_q <= remain_q - burst_len;
        end
        if (t_hs) begin
          out_cnt_q <= out_cnt_q + 32'd1;
        end
        if (r_hs && (m_axi_rresp != AXI_RESP_OKAY)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reserved_q <= '0;
      inflight_q <= '0;
    end else begin
      reserved_q <= reserved_q + (ar_hs ? CW'(burst_len) : CW'(0)) - (r_hs ? CW'(1) : CW'(0));
      case ({ar_hs, rlast_hs})
        2'b10:   inflight_q <= inflight_q + OW'(1);
        2'b01:   inflight_q <= inflight_q - OW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  spmv_stream_fifo #(
    .WIDTH (HBM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (r_hs),
    .in_ready  (fifo_in_ready),
    .in_data   (m_axi_rdata),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (m_axis_tdata),
    .free_cnt  (free_cnt)
  );

endmodule
